// File: rtl/medidor_freq_if.sv
// Measurement-side bundle for the frequency meter: control/signal in, result out.
`timescale 1ns/1ps
interface medidor_freq_if #(
  parameter int COUNT_W = 26
);
  logic               enable;
  logic               sig_in;
  logic [COUNT_W-1:0] freq_out;
  logic               valid;
  logic               overflow;
  logic               busy;

  modport master (output enable, sig_in, input freq_out, valid, overflow, busy);
  modport slave  (input enable, sig_in, output freq_out, valid, overflow, busy);
endinterface

// File: rtl/medidor_freq.sv
// Frequency meter: counts synchronized rising edges of sig_in over a GATE_CYCLES window
// and publishes a saturated count with a one-cycle valid strobe; windows run back to back.
`timescale 1ns/1ps
module medidor_freq #(
  parameter int GATE_CYCLES = 50000000,
  parameter int COUNT_W     = 26
) (
  input  logic           clock_in,
  input  logic           reset_n,
  medidor_freq_if.slave  bus
);
  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t              state;
  logic                s1, s2, s3;
  logic [GATE_W-1:0]   gate_cnt;
  logic [COUNT_W-1:0]  edge_cnt;
  logic                sat;
  logic [COUNT_W-1:0]  freq_q;
  logic                valid_q, ovf_q, busy_q;

  logic                rise;
  logic                lost;
  logic [COUNT_W-1:0]  edge_next;

  // A rise arriving while the counter is already full is lost and flags saturation.
  always_comb begin
    rise      = s2 & ~s3;
    lost      = rise & (&edge_cnt);
    edge_next = edge_cnt;
    if (rise && !(&edge_cnt)) begin
      edge_next = edge_cnt + COUNT_W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat      <= 1'b0;
      freq_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      s1      <= bus.sig_in;
      s2      <= s1;
      s3      <= s2;
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat      <= 1'b0;
          busy_q   <= 1'b0;
          if (bus.enable) begin
            state  <= MEASURE;
            busy_q <= 1'b1;
          end
        end
        MEASURE: begin
          if (!bus.enable) begin
            // Partial window is dropped; published result is left untouched.
            state    <= IDLE;
            busy_q   <= 1'b0;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else if (gate_cnt == GATE_LAST) begin
            freq_q   <= edge_next;
            ovf_q    <= sat | lost;
            valid_q  <= 1'b1;
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
          end else begin
            gate_cnt <= gate_cnt + GATE_W'(1);
            edge_cnt <= edge_next;
            sat      <= sat | lost;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.freq_out = freq_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_medidor_freq.sv
// Directed bench for medidor_freq: 8-bit and 3-bit counters, 100-cycle gate windows.
`timescale 1ns/1ps
module tb_medidor_freq;
  logic clock_in = 1'b0;
  logic reset_n  = 1'b0;
  always #10 clock_in = ~clock_in;

  medidor_freq_if #(.COUNT_W(8)) bus8();
  medidor_freq_if #(.COUNT_W(3)) bus3();

  medidor_freq #(.GATE_CYCLES(100), .COUNT_W(8)) dut8 (
    .clock_in(clock_in), .reset_n(reset_n), .bus(bus8.slave));
  medidor_freq #(.GATE_CYCLES(100), .COUNT_W(3)) dut3 (
    .clock_in(clock_in), .reset_n(reset_n), .bus(bus3.slave));

  // Edges stay 3 ns ahead of every rising clock edge: all half periods are multiples of 20 ns.
  logic sig_gen = 1'b0;
  int   half_ns = 20;
  assign bus8.sig_in = sig_gen;
  assign bus3.sig_in = sig_gen;
  initial begin
    #7;
    forever begin
      if (half_ns == 0) begin
        sig_gen = 1'b0;
        #20;
      end else begin
        #(half_ns) sig_gen = ~sig_gen;
      end
    end
  end

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input bit sel, output int at);
    int n;
    n  = 0;
    at = -1;
    while (n < 400 && at < 0) begin
      @(negedge clock_in);
      n++;
      if (sel ? bus3.valid : bus8.valid) at = cyc;
    end
    if (at < 0) begin
      tests++;
      fails++;
      $display("FAIL valid_timeout: got no valid within %0d cycles, expected one", n);
    end
  endtask

  typedef struct {
    bit sel;
    int half;
    int skip;
    int exp_f;
    bit exp_o;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int prev, at, nv, nb, e, r, f;
    vecs[0] = '{0, 100, 2, 10, 1'b0};
    vecs[1] = '{0,  40, 1, 25, 1'b0};
    vecs[2] = '{0,   0, 1,  0, 1'b0};
    vecs[3] = '{0, 250, 1,  4, 1'b0};
    vecs[4] = '{0,  20, 1, 50, 1'b0};
    vecs[5] = '{1,  40, 1,  7, 1'b1};
    vecs[6] = '{1, 500, 1,  2, 1'b0};

    bus8.enable = 1'b0;
    bus3.enable = 1'b0;

    // Reset held with the input toggling every cycle.
    nv = 0;
    repeat (6) begin
      @(negedge clock_in);
      nv += int'(bus8.valid) + int'(bus3.valid);
    end
    check("rst_freq8", int'(bus8.freq_out), 0);
    check("rst_ovf8",  int'(bus8.overflow), 0);
    check("rst_busy8", int'(bus8.busy), 0);
    check("rst_freq3", int'(bus3.freq_out), 0);
    check("rst_ovf3",  int'(bus3.overflow), 0);
    check("rst_busy3", int'(bus3.busy), 0);
    check("rst_valids", nv, 0);
    #3 reset_n = 1'b1;
    nb = 0;
    nv = 0;
    repeat (10) begin
      @(negedge clock_in);
      nb += int'(bus8.busy) + int'(bus3.busy);
      nv += int'(bus8.valid) + int'(bus3.valid);
    end
    check("idle_busy", nb, 0);
    check("idle_valids", nv, 0);

    bus8.enable = 1'b1;
    bus3.enable = 1'b1;

    foreach (vecs[i]) begin
      half_ns = vecs[i].half;
      prev = -1;
      for (int k = 0; k < vecs[i].skip; k++) wait_valid(vecs[i].sel, prev);
      wait_valid(vecs[i].sel, at);
      if (vecs[i].sel) begin
        check($sformatf("v%0d_freq", i), int'(bus3.freq_out), vecs[i].exp_f);
        check($sformatf("v%0d_ovf", i),  int'(bus3.overflow), int'(vecs[i].exp_o));
      end else begin
        check($sformatf("v%0d_freq", i), int'(bus8.freq_out), vecs[i].exp_f);
        check($sformatf("v%0d_ovf", i),  int'(bus8.overflow), int'(vecs[i].exp_o));
      end
      check($sformatf("v%0d_period", i), at - prev, 100);
      @(negedge clock_in);
      check($sformatf("v%0d_pulse", i), vecs[i].sel ? int'(bus3.valid) : int'(bus8.valid), 0);
    end

    // Enable dropped 60 cycles into a window, then re-enabled.
    half_ns = 100;
    wait_valid(0, prev);
    wait_valid(0, prev);
    while (cyc < prev + 60) @(negedge clock_in);
    bus8.enable = 1'b0;
    @(negedge clock_in);
    check("drop_busy", int'(bus8.busy), 0);
    nv = 0;
    repeat (30) begin
      @(negedge clock_in);
      nv += int'(bus8.valid);
    end
    check("drop_valids", nv, 0);
    check("drop_freq_hold", int'(bus8.freq_out), 10);
    e = cyc;
    bus8.enable = 1'b1;
    wait_valid(0, at);
    check("reen_latency", at - e, 101);
    check("reen_freq", int'(bus8.freq_out), 10);

    // Asynchronous reset pulse mid-window, off the clock edge.
    wait_valid(0, prev);
    repeat (40) @(negedge clock_in);
    #3 reset_n = 1'b0;
    #1;
    check("arst_freq8", int'(bus8.freq_out), 0);
    check("arst_valid8", int'(bus8.valid), 0);
    check("arst_ovf8", int'(bus8.overflow), 0);
    check("arst_busy8", int'(bus8.busy), 0);
    check("arst_freq3", int'(bus3.freq_out), 0);
    @(negedge clock_in);
    @(negedge clock_in);
    #4 reset_n = 1'b1;
    r = cyc;
    wait_valid(0, at);
    check("arst_restart_latency", at - r, 101);
    f = int'(bus8.freq_out);
    check("arst_restart_count_near_10", int'(f >= 9 && f <= 11), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end
endmodule
